// File: rtl/watch_mode_sequencer_pkg.sv
// Shared encodings and FSM state types for the watch mode sequencer.
// The mode encodings are also consumed by the timer datapath.
package watch_pkg;

    // Mode encodings
    localparam logic [1:0] MODE_TIMER     = 2'b00;
    localparam logic [1:0] MODE_STOPWATCH = 2'b01;
    localparam logic [1:0] MODE_CLOCK     = 2'b10;
    localparam logic [1:0] MODE_ALARM     = 2'b11;

    // Ring source encodings
    localparam logic [1:0] RING_NONE  = 2'b00;
    localparam logic [1:0] RING_TIMER = 2'b01;
    localparam logic [1:0] RING_CLOCK = 2'b10;

    // Number of lap slots
    localparam int MAX_LAPS = 10;

    typedef enum logic [1:0] {
        T_IDLE  = 2'b00,
        T_RUN   = 2'b01,
        T_PAUSE = 2'b10
    } timerState_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_RUN     = 2'b01,
        S_STOPPED = 2'b10
    } swState_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RING = 1'b1
    } ringState_t;

endpackage

// File: rtl/watch_mode_sequencer_button_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a debouncer that
// emits a single registered press pulse once the synchronised input has
// been high for DEBOUNCE_CYCLES consecutive samples. It rearms only after
// a genuine synchronised low, so a button held through reset never fires.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 2
) (
    input  logic clockSignal,
    input  logic startOrStop,
    input  logic btnRaw,
    output logic pressPulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_r;
    logic          sync2_r;
    logic [1:0]    warm_r;
    logic          blocked_r;
    logic          press_r;
    logic [CW-1:0] count_r;

    // Synchronise the raw button; warm_r marks when sync2_r holds a real sample
    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            warm_r  <= 2'b00;
        end else begin
            sync1_r <= btnRaw;
            sync2_r <= sync1_r;
            warm_r  <= {warm_r[0], 1'b1};
        end
    end

    // Count stable-high samples and fire once per low-to-high transition
    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop) begin
            count_r   <= {CW{1'b0}};
            blocked_r <= 1'b1;
            press_r   <= 1'b0;
        end else if (!warm_r[1]) begin
            press_r <= 1'b0;
        end else if (!sync2_r) begin
            count_r   <= {CW{1'b0}};
            blocked_r <= 1'b0;
            press_r   <= 1'b0;
        end else if (blocked_r) begin
            press_r <= 1'b0;
        end else if (count_r == CW'(DEBOUNCE_CYCLES - 1)) begin
            count_r   <= count_r + CW'(1);
            blocked_r <= 1'b1;
            press_r   <= 1'b1;
        end else begin
            count_r <= count_r + CW'(1);
            press_r <= 1'b0;
        end
    end

    assign pressPulse = press_r;

endmodule

// File: rtl/watch_mode_sequencer.sv
// Watch mode sequencer: turns three raw buttons and datapath events into
// mode selection, timer/stopwatch/alarm commands and a prioritised ringer.
// All outputs come straight from flops.
module watch_mode_sequencer #(
    parameter int DEBOUNCE_CYCLES = 2,
    parameter int RING_CYCLES     = 3000,
    parameter int MAX_LAPS        = watch_pkg::MAX_LAPS
) (
    input  logic       clockSignal,
    input  logic       startOrStop,
    input  logic       btnMode,
    input  logic       btnSet,
    input  logic       btnSplit,
    input  logic       timerExpired,
    input  logic       clockAlarmHit,
    input  logic       swOverflow,
    output logic [1:0] mode,
    output logic       timerLoad,
    output logic       timerClear,
    output logic       timerRun,
    output logic       swRun,
    output logic       lapStrobe,
    output logic [3:0] lapIndex,
    output logic       clearLaps,
    output logic       clearClock,
    output logic       loadAlarm,
    output logic       alarmArmed,
    output logic       ringSound,
    output logic [1:0] ringSource
);

    import watch_pkg::*;

    localparam int RW = $clog2(RING_CYCLES + 1);

    logic pressMode_s, pressSet_s, pressSplit_s;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) modeDebounce (
        .clockSignal(clockSignal), .startOrStop(startOrStop), .btnRaw(btnMode),  .pressPulse(pressMode_s));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) setDebounce (
        .clockSignal(clockSignal), .startOrStop(startOrStop), .btnRaw(btnSet),   .pressPulse(pressSet_s));
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) splitDebounce (
        .clockSignal(clockSignal), .startOrStop(startOrStop), .btnRaw(btnSplit), .pressPulse(pressSplit_s));

    // State and registered outputs
    timerState_t   timerState_r, timerNext_s;
    swState_t      swState_r, swNext_s;
    ringState_t    ringState_r, ringNext_s;
    logic [1:0]    modeSel_r, modeNext_s;
    logic [3:0]    lapIndex_r, lapNext_s;
    logic [RW-1:0] ringCount_r, countNext_s;
    logic [1:0]    ringSource_r, sourceNext_s;
    logic          alarmArmed_r, armedNext_s;
    logic          pendTimer_r, pendTimerNext_s, pendClock_r, pendClockNext_s;
    logic          timerLoad_r, timerClear_r, timerRun_r, swRun_r, lapStrobe_r;
    logic          clearLaps_r, clearClock_r, loadAlarm_r, ringSound_r;
    logic          loadNext_s, clearNext_s, lapStrobeNext_s, clearLapsNext_s;
    logic          clearClockNext_s, loadAlarmNext_s;

    // Press arbitration: split beats set beats mode; presses during a ring only acknowledge it
    logic ringing_s, splitAct_s, setAct_s, modeAct_s, anyPress_s;
    logic timerReq_s, clockReq_s;
    always_comb begin
        ringing_s  = (ringState_r == R_RING);
        anyPress_s = pressSplit_s | pressSet_s | pressMode_s;
        splitAct_s = pressSplit_s & ~ringing_s;
        setAct_s   = pressSet_s & ~pressSplit_s & ~ringing_s;
        modeAct_s  = pressMode_s & ~pressSplit_s & ~pressSet_s & ~ringing_s;
    end

    // Mode selector and timer FSM; expiry while running takes precedence over presses
    always_comb begin
        modeNext_s  = modeAct_s ? (modeSel_r + 2'b01) : modeSel_r;
        timerNext_s = timerState_r;
        loadNext_s  = 1'b0;
        clearNext_s = 1'b0;
        timerReq_s  = 1'b0;
        if (timerExpired && (timerState_r == T_RUN)) begin
            timerNext_s = T_IDLE;
            timerReq_s  = 1'b1;
        end else if ((modeSel_r == MODE_TIMER) && splitAct_s) begin
            timerNext_s = T_IDLE;
            clearNext_s = 1'b1;
        end else if ((modeSel_r == MODE_TIMER) && setAct_s) begin
            case (timerState_r)
                T_IDLE:  begin timerNext_s = T_RUN; loadNext_s = 1'b1; end
                T_RUN:   timerNext_s = T_PAUSE;
                T_PAUSE: timerNext_s = T_RUN;
                default: timerNext_s = T_IDLE;
            endcase
        end else begin
            timerNext_s = timerState_r;
        end
    end

    // Stopwatch FSM and lap slot; the slot advances the cycle after its strobe
    always_comb begin
        swNext_s        = swState_r;
        lapStrobeNext_s = 1'b0;
        clearLapsNext_s = 1'b0;
        if (lapStrobe_r) begin
            lapNext_s = (lapIndex_r == 4'(MAX_LAPS - 1)) ? 4'd0 : (lapIndex_r + 4'd1);
        end else begin
            lapNext_s = lapIndex_r;
        end
        if (swOverflow && (swState_r == S_RUN)) begin
            swNext_s = S_STOPPED;
        end else if ((modeSel_r == MODE_STOPWATCH) && splitAct_s) begin
            if (swState_r == S_RUN) begin
                lapStrobeNext_s = 1'b1;
            end else begin
                clearLapsNext_s = 1'b1;
                lapNext_s       = 4'd0;
                swNext_s        = S_IDLE;
            end
        end else if ((modeSel_r == MODE_STOPWATCH) && setAct_s) begin
            swNext_s = (swState_r == S_RUN) ? S_STOPPED : S_RUN;
        end else begin
            swNext_s = swState_r;
        end
    end

    // Clock view and alarm arming; an alarm hit consumes the arm
    always_comb begin
        clearClockNext_s = (modeSel_r == MODE_CLOCK) && splitAct_s;
        loadAlarmNext_s  = 1'b0;
        clockReq_s       = clockAlarmHit && alarmArmed_r;
        if ((modeSel_r == MODE_ALARM) && setAct_s) begin
            loadAlarmNext_s = 1'b1;
            armedNext_s     = 1'b1;
        end else if (clockReq_s || ((modeSel_r == MODE_ALARM) && splitAct_s)) begin
            armedNext_s = 1'b0;
        end else begin
            armedNext_s = alarmArmed_r;
        end
    end

    // Ring FSM: timer outranks clock, losers wait pending, next ring starts right after exit
    logic wantTimer_s, wantClock_s, ringDone_s, canGrant_s;
    always_comb begin
        wantTimer_s     = pendTimer_r | timerReq_s;
        wantClock_s     = pendClock_r | clockReq_s;
        ringDone_s      = ringing_s && ((ringCount_r == {RW{1'b0}}) || anyPress_s);
        canGrant_s      = ~ringing_s | ringDone_s;
        ringNext_s      = ringState_r;
        countNext_s     = ringCount_r;
        sourceNext_s    = ringSource_r;
        pendTimerNext_s = wantTimer_s;
        pendClockNext_s = wantClock_s;
        if (canGrant_s && wantTimer_s) begin
            ringNext_s      = R_RING;
            countNext_s     = RW'(RING_CYCLES - 1);
            sourceNext_s    = RING_TIMER;
            pendTimerNext_s = 1'b0;
        end else if (canGrant_s && wantClock_s) begin
            ringNext_s      = R_RING;
            countNext_s     = RW'(RING_CYCLES - 1);
            sourceNext_s    = RING_CLOCK;
            pendClockNext_s = 1'b0;
        end else if (ringDone_s) begin
            ringNext_s   = R_IDLE;
            countNext_s  = {RW{1'b0}};
            sourceNext_s = RING_NONE;
        end else if (ringing_s) begin
            countNext_s = ringCount_r - RW'(1);
        end else begin
            ringNext_s = R_IDLE;
        end
    end

    // State and output registers
    always_ff @(posedge clockSignal or posedge startOrStop) begin
        if (startOrStop) begin
            timerState_r <= T_IDLE;
            swState_r    <= S_IDLE;
            ringState_r  <= R_IDLE;
            modeSel_r    <= MODE_TIMER;
            lapIndex_r   <= 4'd0;
            ringCount_r  <= {RW{1'b0}};
            ringSource_r <= RING_NONE;
            alarmArmed_r <= 1'b0;
            pendTimer_r  <= 1'b0;
            pendClock_r  <= 1'b0;
            timerLoad_r  <= 1'b0;
            timerClear_r <= 1'b0;
            timerRun_r   <= 1'b0;
            swRun_r      <= 1'b0;
            lapStrobe_r  <= 1'b0;
            clearLaps_r  <= 1'b0;
            clearClock_r <= 1'b0;
            loadAlarm_r  <= 1'b0;
            ringSound_r  <= 1'b0;
        end else begin
            timerState_r <= timerNext_s;
            swState_r    <= swNext_s;
            ringState_r  <= ringNext_s;
            modeSel_r    <= modeNext_s;
            lapIndex_r   <= lapNext_s;
            ringCount_r  <= countNext_s;
            ringSource_r <= sourceNext_s;
            alarmArmed_r <= armedNext_s;
            pendTimer_r  <= pendTimerNext_s;
            pendClock_r  <= pendClockNext_s;
            timerLoad_r  <= loadNext_s;
            timerClear_r <= clearNext_s;
            timerRun_r   <= (timerNext_s == T_RUN);
            swRun_r      <= (swNext_s == S_RUN);
            lapStrobe_r  <= lapStrobeNext_s;
            clearLaps_r  <= clearLapsNext_s;
            clearClock_r <= clearClockNext_s;
            loadAlarm_r  <= loadAlarmNext_s;
            ringSound_r  <= (ringNext_s == R_RING);
        end
    end

    assign mode       = modeSel_r;
    assign timerLoad  = timerLoad_r;
    assign timerClear = timerClear_r;
    assign timerRun   = timerRun_r;
    assign swRun      = swRun_r;
    assign lapStrobe  = lapStrobe_r;
    assign lapIndex   = lapIndex_r;
    assign clearLaps  = clearLaps_r;
    assign clearClock = clearClock_r;
    assign loadAlarm  = loadAlarm_r;
    assign alarmArmed = alarmArmed_r;
    assign ringSound  = ringSound_r;
    assign ringSource = ringSource_r;

endmodule

// File: doc/watch_mode_sequencer.md
WATCH_MODE_SEQUENCER -- requirements
Module: watch_mode_sequencer

Interface
REQ-001 The block SHALL use reset startOrStop, asynchronous, active-high; clock clockSignal.
REQ-002 Parameter DEBOUNCE_CYCLES, default 2, SHALL set the number of consecutive stable-high synchronised samples needed to accept a press.
REQ-003 Parameter RING_CYCLES, default 3000, SHALL set the maximum ring duration in clock cycles (30 s at 100 Hz).
REQ-004 Parameter MAX_LAPS, default 10, SHALL set the number of lap slots.
REQ-005 Ports SHALL be, in order:
- clockSignal  in  1  100 Hz clock.
- startOrStop  in  1  async reset.
- btnMode  in  1  raw mode button.
- btnSet  in  1  raw set/start button.
- btnSplit  in  1  raw split/reset button.
- timerExpired  in  1  datapath countdown reached 0, one-cycle pulse.
- clockAlarmHit  in  1  datapath time-of-day equals alarm, one-cycle pulse.
- swOverflow  in  1  stopwatch passed 24 h, one-cycle pulse.
- mode  out  2  current mode: 00 timer, 01 stopwatch, 10 view clock, 11 set alarm.
- timerLoad, timerClear, timerRun  out  1 each  timer commands; load/clear are pulses, run is a level.
- swRun  out  1  stopwatch count enable, level.
- lapStrobe  out  1  capture-lap pulse.
- lapIndex  out  4  slot written on lapStrobe.
- clearLaps, clearClock, loadAlarm  out  1 each  one-cycle pulses.
- alarmArmed  out  1  clock alarm enabled.
- ringSound  out  1  ringer drive.
- ringSource  out  2  00 none, 01 timer, 10 clock.

Function
REQ-006 Each button SHALL pass through a 2-flop synchroniser and a debouncer. The debouncer emits one press pulse in the cycle its stable-high count reaches DEBOUNCE_CYCLES, then rearms only after a synchronised low.
REQ-007 All outputs SHALL be registered. A command pulse SHALL appear exactly 3+DEBOUNCE_CYCLES rising edges after the raw button is first sampled high, and SHALL last exactly one cycle.
REQ-008 If several press pulses occur in the same cycle, split SHALL win over set, set SHALL win over mode, and the losers SHALL be discarded.
REQ-009 A mode press SHALL advance mode by 1 modulo 4 (11 wraps to 00). A running timer or stopwatch SHALL continue across mode changes.
REQ-010 The timer FSM SHALL have states T_IDLE, T_RUN, T_PAUSE, with timerRun=1 only in T_RUN.
- Set in mode 00: T_IDLE->T_RUN plus a timerLoad pulse; T_RUN->T_PAUSE; T_PAUSE->T_RUN.
- Split in mode 00: any state->T_IDLE plus a timerClear pulse.
- timerExpired in T_RUN: ->T_IDLE and a timer ring request. timerExpired is ignored in other states.
REQ-011 The stopwatch FSM SHALL have states S_IDLE, S_RUN, S_STOPPED, with swRun=1 only in S_RUN.
- Set in mode 01: S_IDLE or S_STOPPED->S_RUN; S_RUN->S_STOPPED.
- Split in mode 01, in S_RUN: lapStrobe with the current lapIndex, then lapIndex increments, wrapping from MAX_LAPS-1 to 0.
- Split in mode 01, in S_IDLE or S_STOPPED: clearLaps pulse, lapIndex=0, ->S_IDLE.
- swOverflow in S_RUN: ->S_STOPPED.
REQ-012 In mode 10, set SHALL do nothing, and split SHALL pulse clearClock.
REQ-013 In mode 11, set SHALL pulse loadAlarm and set alarmArmed=1. Split SHALL clear alarmArmed.
REQ-014 clockAlarmHit SHALL raise a clock ring request only while alarmArmed=1, and SHALL clear alarmArmed in the same cycle (one-shot).
REQ-015 The ring FSM SHALL have states R_IDLE and R_RING, with ringSound=1 only in R_RING.
- Entry: load a counter with RING_CYCLES-1 and drive ringSource with the granted source.
- Exit to R_IDLE: when the counter reaches 0, or on any press pulse.
REQ-016 A press pulse arriving while in R_RING SHALL only acknowledge the ring and SHALL cause no mode, timer, stopwatch or alarm action.
REQ-017 When timer and clock requests arrive together, the timer SHALL be granted and the clock request SHALL be held pending.
REQ-018 A pending request, or a new request arriving during R_RING, SHALL be held and SHALL ring starting in the cycle after R_RING exits. At most one pending request per source is held.
REQ-019 timerRun and swRun SHALL remain unaffected by ringing.

Reset
REQ-020 While startOrStop is high, all outputs SHALL be 0, mode SHALL be 00, and lapIndex SHALL be 0.
REQ-021 While startOrStop is high, all FSMs SHALL be in T_IDLE, S_IDLE and R_IDLE, pending requests and debouncers SHALL be cleared, and alarmArmed SHALL be 0.
REQ-022 Reset assertion mid-ring or mid-count SHALL abort immediately with no completion pulse.
REQ-023 After reset deassertion, the first accepted press SHALL require a fresh low-to-high transition.

Structure
REQ-024 Package watch_pkg SHALL hold:
- the mode encodings (shared with the timer datapath);
- the ringSource encodings;
- MAX_LAPS;
- the timer, stopwatch and ring FSM state types.
REQ-025 One sub-module, button_debounce, SHALL be instantiated three times, once per button. All FSMs SHALL stay in the top module.

Verification
REQ-026 Reset, then btnMode held 4 cycles with DEBOUNCE_CYCLES=2 -> mode 00->01 at edge 5 after the press; no other pulses.
REQ-027 Mode 00: set -> timerLoad pulse and timerRun=1. Set again -> timerRun=0. Then timerExpired in T_PAUSE -> no ring.
REQ-028 Mode 01 running: 11 splits -> lapStrobe with lapIndex 0..9 then 0. Set, then split -> clearLaps and lapIndex=0.
REQ-029 timerExpired and clockAlarmHit in the same cycle with alarmArmed=1 -> ringSource=01 for 3000 cycles, then ringSource=10 on the next cycle, and alarmArmed=0.
REQ-030 During a ring, btnSplit and btnSet pressed together -> ringSound=0 next cycle, no timerClear. Reset asserted mid-ring -> all outputs 0 asynchronously.
